// File: rtl/tt_um_mng2_ncos_pkg.sv
// Shared constants for the four-channel NCO bank tile: sizes, pin indices
// and the channel-select decode helper.
package tt_um_mng2_ncos_pkg;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned NIB_W    = 4;

    // uio_in / uio_out pin map
    localparam int unsigned SEL_LSB  = 0;
    localparam int unsigned BYTE_BIT = 2;
    localparam int unsigned STB_BIT  = 3;
    localparam int unsigned WRAP_LSB = 4;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

    typedef enum logic {
        BYTE_LO = 1'b0,
        BYTE_HI = 1'b1
    } byte_sel_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: 16-bit phase accumulator with a byte-writable frequency
// tuning word and a registered carry-out (wrap) flag.
module nco_channel
    import tt_um_mng2_ncos_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [7:0]       wdata,
    output logic [ACC_W-1:0] acc,
    output logic             wrap
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_q, ftw_d;
    logic             wrap_q, wrap_d;
    logic [ACC_W:0]   sum;

    // Accumulation always uses the FTW held before this edge's write.
    assign sum = {1'b0, acc_q} + {1'b0, ftw_q};

    always_comb begin
        acc_d  = sum[ACC_W-1:0];
        wrap_d = sum[ACC_W];
        ftw_d  = ftw_q;
        if (wr_lo) begin
            ftw_d[7:0] = wdata;
        end
        if (wr_hi) begin
            ftw_d[ACC_W-1:8] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ftw_q  <= '0;
            wrap_q <= 1'b0;
        end else if (en) begin
            acc_q  <= acc_d;
            ftw_q  <= ftw_d;
            wrap_q <= wrap_d;
        end
    end

    assign acc  = acc_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/tt_um_mng2_ncos.sv
// TinyTapeout tile wrapping four NCO channels: strobe edge detect, byte-write
// decode, square/wrap outputs and the phase-nibble mux.
module tt_um_mng2_ncos
    import tt_um_mng2_ncos_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic              strobe_q, strobe_d;
    logic              wr_fire;
    logic [SEL_W-1:0]  sel;
    byte_sel_e         byte_sel;
    logic [NUM_CH-1:0] wr_lo, wr_hi;
    logic [NUM_CH-1:0] sq, wrap;
    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [NIB_W-1:0]  nib;
    logic              unused_uio;

    assign sel      = uio_in[SEL_LSB +: SEL_W];
    assign byte_sel = byte_sel_e'(uio_in[BYTE_BIT]);
    assign strobe_d = uio_in[STB_BIT];

    // strobe_q only advances while enabled, so edges during ena=0 are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
        end else if (ena) begin
            strobe_q <= strobe_d;
        end
    end

    assign wr_fire = ena & strobe_d & ~strobe_q;

    always_comb begin
        wr_lo = '0;
        wr_hi = '0;
        if (wr_fire) begin
            if (byte_sel == BYTE_HI) begin
                wr_hi = ch_onehot(sel);
            end else begin
                wr_lo = ch_onehot(sel);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nco_channel u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (ena),
            .wr_lo (wr_lo[i]),
            .wr_hi (wr_hi[i]),
            .wdata (ui_in),
            .acc   (acc[i]),
            .wrap  (wrap[i])
        );
        assign sq[i] = acc[i][ACC_W-1];
    end

    always_comb begin
        nib = acc[sel][ACC_W-1 -: NIB_W];
    end

    always_comb begin
        uo_out                       = '0;
        uo_out[NUM_CH-1:0]           = sq;
        uo_out[NUM_CH +: NIB_W]      = nib;
        uio_out                      = '0;
        uio_out[WRAP_LSB +: NUM_CH]  = wrap;
    end

    assign uio_oe = UIO_OE_VAL;

    assign unused_uio = &{1'b0, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_mng2_ncos.sv
// Directed bench for the NCO bank tile: vector table plus hand sequences.
module tb_tt_um_mng2_ncos;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned checks = 0;
    int unsigned errors = 0;

    tt_um_mng2_ncos dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ena;
        logic [7:0] uio;
        logic [7:0] ui;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t tbl [19];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
    endtask

    // Two enabled edges: strobe high (write fires), then strobe low.
    task automatic wr(input logic [1:0] ch, input logic hi, input logic [7:0] d);
        ui_in  = d;
        uio_in = {4'b0000, 1'b1, hi, ch};
        step();
        uio_in = {4'b0000, 1'b0, hi, ch};
        step();
    endtask

    initial begin
        logic [3:0] nib;

        // ch3: hi=0x40, then lo written by a held strobe, wraps every 4th
        // cycle, then an ena=0 window with a masked strobe edge.
        tbl[0]  = '{1'b1, 8'h0F, 8'h40, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 8'h03, 8'h00, 8'h40, 8'h00};
        tbl[2]  = '{1'b1, 8'h0B, 8'h01, 8'h88, 8'h00};
        tbl[3]  = '{1'b1, 8'h0B, 8'h02, 8'hC8, 8'h00};
        tbl[4]  = '{1'b1, 8'h0B, 8'h03, 8'h00, 8'h80};
        tbl[5]  = '{1'b1, 8'h0B, 8'h04, 8'h40, 8'h00};
        tbl[6]  = '{1'b1, 8'h0B, 8'h05, 8'h88, 8'h00};
        tbl[7]  = '{1'b1, 8'h0B, 8'h06, 8'hC8, 8'h00};
        tbl[8]  = '{1'b1, 8'h0B, 8'h07, 8'h00, 8'h80};
        tbl[9]  = '{1'b1, 8'h0B, 8'h08, 8'h40, 8'h00};
        tbl[10] = '{1'b1, 8'h0B, 8'h09, 8'h88, 8'h00};
        tbl[11] = '{1'b1, 8'h0B, 8'h0A, 8'hC8, 8'h00};
        tbl[12] = '{1'b1, 8'h03, 8'h55, 8'h00, 8'h80};
        tbl[13] = '{1'b0, 8'h0F, 8'h00, 8'h00, 8'h80};
        tbl[14] = '{1'b0, 8'h0F, 8'h00, 8'h00, 8'h80};
        tbl[15] = '{1'b1, 8'h03, 8'h00, 8'h40, 8'h00};
        tbl[16] = '{1'b1, 8'h03, 8'h00, 8'h88, 8'h00};
        tbl[17] = '{1'b0, 8'h00, 8'h00, 8'h08, 8'h00};
        tbl[18] = '{1'b0, 8'h01, 8'h00, 8'h08, 8'h00};

        // Reset with random inputs, then 100 idle cycles.
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        for (int i = 0; i < 4; i++) begin
            ui_in  = 8'($urandom);
            uio_in = 8'($urandom);
            ena    = 1'($urandom);
            step();
            chk("rst_uo", uo_out, 8'h00);
            chk("rst_uio", uio_out, 8'h00);
            chk("rst_oe", uio_oe, 8'hF0);
        end
        ena    = 1'b1;
        uio_in = 8'h00;
        rst_n  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ui_in  = 8'($urandom);
            uio_in = {4'($urandom), 1'b0, 3'($urandom)};
            step();
            chk("idle_uo", uo_out, 8'h00);
            chk("idle_uio", uio_out, 8'h00);
        end

        // Vector table.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            ena    = tbl[i].ena;
            uio_in = tbl[i].uio;
            ui_in  = tbl[i].ui;
            step();
            chk($sformatf("tbl%0d_uo", i), uo_out, tbl[i].exp_uo);
            chk($sformatf("tbl%0d_uio", i), uio_out, tbl[i].exp_uio);
        end
        chk("tbl_oe", uio_oe, 8'hF0);

        // Full-scale ch0: FTW=0x8000, square toggles and wrap every 2nd cycle.
        do_reset();
        wr(2'd0, 1'b1, 8'h80);
        wr(2'd0, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fs%0d_uo", k), uo_out, (k % 2 == 0) ? 8'h81 : 8'h00);
            chk($sformatf("fs%0d_uio", k), uio_out, (k % 2 == 0) ? 8'h00 : 8'h10);
            step();
        end

        // Slow ch1: FTW=0x1000, nibble counts up, wrap once per 16 cycles.
        do_reset();
        wr(2'd1, 1'b1, 8'h10);
        wr(2'd1, 1'b0, 8'h00);
        for (int k = 0; k < 34; k++) begin
            nib = 4'((3 + k) % 16);
            chk($sformatf("slow%0d_uo", k), uo_out, {nib, 2'b00, nib[3], 1'b0});
            chk($sformatf("slow%0d_uio", k), uio_out, (nib == 4'h0) ? 8'h20 : 8'h00);
            step();
        end

        // Held strobe on ch3 lo: only 0x01 lands, so acc = n-1 after edge n.
        do_reset();
        for (int v = 1; v <= 10; v++) begin
            ui_in  = 8'(v);
            uio_in = 8'h0B;
            step();
        end
        uio_in = 8'h03;
        ui_in  = 8'h00;
        step();
        chk("held_e11", uo_out, 8'h00);
        for (int n = 12; n <= 4096; n++) begin
            step();
        end
        chk("held_e4096", uo_out, 8'h00);
        step();
        chk("held_e4097", uo_out, 8'h10);

        // ena freeze on ch2 (FTW=0x0100).
        do_reset();
        wr(2'd2, 1'b1, 8'h01);
        for (int k = 0; k < 49; k++) begin
            step();
        end
        chk("frz_pre", uo_out, 8'h30);
        ena = 1'b0;
        for (int k = 0; k < 20; k++) begin
            uio_in = (k % 2 == 1) ? 8'h0E : 8'h06;
            ui_in  = 8'hFF;
            step();
            chk($sformatf("frz%0d_uo", k), uo_out, 8'h30);
            chk($sformatf("frz%0d_uio", k), uio_out, 8'h00);
        end
        uio_in = 8'h06;
        ena    = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
        end
        chk("frz_res13", uo_out, 8'h30);
        step();
        chk("frz_res14", uo_out, 8'h40);

        // Mid-run asynchronous reset with all four channels running.
        do_reset();
        wr(2'd0, 1'b1, 8'h80);
        wr(2'd1, 1'b1, 8'h10);
        wr(2'd2, 1'b1, 8'h30);
        wr(2'd3, 1'b1, 8'h50);
        for (int k = 0; k < 37; k++) begin
            step();
        end
        chk("mid_pre_uo", uo_out, 8'hEE);
        chk("mid_pre_uio", uio_out, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_uo", uo_out, 8'h00);
        chk("mid_async_uio", uio_out, 8'h00);
        chk("mid_async_oe", uio_oe, 8'hF0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            uio_in = {5'b00000, 1'($urandom), 2'(k)};
            step();
            chk($sformatf("mid_post%0d_uo", k), uo_out, 8'h00);
            chk($sformatf("mid_post%0d_uio", k), uio_out, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
